// File: rtl/mua_p2s_serializer.sv
// mua_p2s_serializer: wide-beat to serial-lane converter for the MUA output path.
// Each accepted beat of NUM_BANKS lanes is offset-corrected, registered once,
// buffered in a small FIFO and replayed one lane per cycle on a valid/ready
// stream tagged with a running frame number.
// Optional build macro MUA_SAT_SUB_EN: signed saturating offset subtraction
// instead of modulo subtraction.
module mua_p2s_serializer #(
  parameter int NUM_BANKS  = 5,
  parameter int DATA_W     = 32,
  parameter int CH_W       = 12,
  parameter int NUM_CH     = 160,
  parameter int FIFO_DEPTH = 4,
  parameter int CLR_LSB    = 1
) (
  input  logic                        bus_clk,
  input  logic                        xike_reset_n,
  input  logic                        frame_count_rst,
  input  logic                        comb_valid,
  output logic                        comb_ready,
  input  logic [NUM_BANKS*CH_W-1:0]   comb_ch,
  input  logic [NUM_BANKS*DATA_W-1:0] comb_data,
  input  logic [NUM_BANKS*DATA_W-1:0] comb_hash,
  input  logic [NUM_BANKS*DATA_W-1:0] comb_thr,
  input  logic [NUM_BANKS*DATA_W-1:0] comb_offset,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [CH_W-1:0]             out_ch,
  output logic [DATA_W-1:0]           out_data,
  output logic [DATA_W-1:0]           out_thr,
  output logic [DATA_W-1:0]           out_hash,
  output logic                        out_last,
  output logic [31:0]                 out_frame_no,
  output logic [15:0]                 drop_cnt
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW = $clog2(NUM_BANKS);
  localparam logic [LW-1:0] LAST_LANE = LW'(NUM_BANKS - 1);

  typedef struct packed {
    logic [CH_W-1:0]   ch;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] hash;
    logic [DATA_W-1:0] thr;
  } lane_t;

  typedef lane_t [NUM_BANKS-1:0] beat_t;

  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

  // Raw data minus per-lane offset, then optional clearing of bit 0.
  function automatic logic [DATA_W-1:0] offset_correct(input logic [DATA_W-1:0] data,
                                                       input logic [DATA_W-1:0] offset);
    logic [DATA_W-1:0] res;
`ifdef MUA_SAT_SUB_EN
    logic [DATA_W:0] diff;
    // One extra sign bit exposes overflow: the top two bits disagree.
    diff = {data[DATA_W-1], data} - {offset[DATA_W-1], offset};
    if (diff[DATA_W] != diff[DATA_W-1])
      res = diff[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    else
      res = diff[DATA_W-1:0];
`else
    res = data - offset;
`endif
    if (CLR_LSB != 0) res[0] = 1'b0;
    return res;
  endfunction

  beat_t           in_beat;
  beat_t           pipe_beat;
  logic            pipe_valid;
  beat_t           mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     fifo_count;
  logic            fifo_full;
  logic            fifo_empty;
  beat_t           head;
  logic            accept;
  logic            push;
  logic            pop;
  logic            out_fire;
  state_t          state;
  logic [LW-1:0]   lane;
  logic [LW-1:0]   lane_inc;
  beat_t           shift_beat;

  // The pipeline slot counts toward fullness so an accepted beat always has room.
  assign fifo_full  = (32'(fifo_count) + 32'(pipe_valid)) >= 32'(FIFO_DEPTH);
  assign fifo_empty = (fifo_count == '0);
  assign comb_ready = xike_reset_n && !fifo_full;
  assign accept     = comb_valid && comb_ready;
  assign push       = pipe_valid;
  assign head       = mem[rd_ptr];
  assign out_fire   = out_valid && out_ready;
  // Load the shifter when idle, or back-to-back as the last lane leaves.
  assign pop        = !fifo_empty && ((state == ST_IDLE) || (out_fire && out_last));
  assign lane_inc   = lane + 1'b1;

  // Unpack the input buses into lanes and apply the offset correction.
  always_comb begin
    // NOTE: default first so every path assigns the whole beat and no latch is inferred.
    in_beat = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      in_beat[i].ch   = comb_ch[i*CH_W +: CH_W];
      in_beat[i].data = offset_correct(comb_data[i*DATA_W +: DATA_W],
                                       comb_offset[i*DATA_W +: DATA_W]);
      in_beat[i].hash = comb_hash[i*DATA_W +: DATA_W];
      in_beat[i].thr  = comb_thr[i*DATA_W +: DATA_W];
    end
  end

  // Register the corrected beat one cycle ahead of the FIFO write.
  always_ff @(posedge bus_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!xike_reset_n) pipe_valid <= 1'b0;
    else               pipe_valid <= accept;
    if (accept) pipe_beat <= in_beat;
  end

  // FIFO storage write port.
  always_ff @(posedge bus_clk) begin
    // NOTE: the storage array is not reset; the pointers and count alone define what is valid.
    if (push) mem[wr_ptr] <= pipe_beat;
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge bus_clk) begin
    if (!xike_reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Shift register holding the beat currently being serialised.
  always_ff @(posedge bus_clk) begin
    if (pop) shift_beat <= head;
  end

  // Serialiser FSM with registered lane outputs; a stalled handshake holds everything.
  always_ff @(posedge bus_clk) begin
    if (!xike_reset_n) begin
      state     <= ST_IDLE;
      lane      <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_ch    <= '0;
      out_data  <= '0;
      out_thr   <= '0;
      out_hash  <= '0;
    end else if (pop) begin
      state     <= ST_SHIFT;
      lane      <= '0;
      out_valid <= 1'b1;
      out_last  <= 1'b0;
      out_ch    <= head[0].ch;
      out_data  <= head[0].data;
      out_thr   <= head[0].thr;
      out_hash  <= head[0].hash;
    end else if (out_fire) begin
      if (out_last) begin
        state     <= ST_IDLE;
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end else begin
        lane     <= lane_inc;
        out_last <= (lane_inc == LAST_LANE);
        out_ch   <= shift_beat[lane_inc].ch;
        out_data <= shift_beat[lane_inc].data;
        out_thr  <= shift_beat[lane_inc].thr;
        out_hash <= shift_beat[lane_inc].hash;
      end
    end
  end

  // Frame counter: advances after the closing channel leaves; clear has priority.
  always_ff @(posedge bus_clk) begin
    if (!xike_reset_n)                                    out_frame_no <= '0;
    else if (frame_count_rst)                             out_frame_no <= '0;
    else if (out_fire && (out_ch == CH_W'(NUM_CH - 1)))   out_frame_no <= out_frame_no + 32'd1;
  end

  // Saturating count of beats refused because the buffer was full.
  always_ff @(posedge bus_clk) begin
    if (!xike_reset_n)
      drop_cnt <= '0;
    else if (comb_valid && !comb_ready && (drop_cnt != 16'hFFFF))
      drop_cnt <= drop_cnt + 16'd1;
  end

endmodule

// File: doc/mua_p2s_serializer.md
Name: mua_p2s_serializer

Overview:
Parametrised successor of the fixed 5-bank MUA parallel-to-serial stage. Accepts one wide beat per cycle of NUM_BANKS lanes carrying data, channel, channel hash, threshold and per-lane offset. Buffers beats in an internal FIFO and emits one lane per cycle, in a single coherent valid/ready stream with a frame number. Sits between the MUA bank combiner and the MUA output FIFO.

Parameters:
NUM_BANKS, 5, lanes per input beat (>=2)
DATA_W, 32, width of data/threshold/hash/offset per lane
CH_W, 12, channel id width per lane
NUM_CH, 160, channel count; channel NUM_CH-1 closes a frame
FIFO_DEPTH, 4, wide-beat buffer depth (power of 2, >=2)
CLR_LSB, 1, 1 = force bit 0 of each offset-corrected data lane to 0

Ports:
bus_clk  in  1  clock
xike_reset_n  in  1  synchronous active-low reset
frame_count_rst  in  1  synchronous active-high frame counter clear
comb_valid  in  1  wide beat valid
comb_ready  out  1  wide beat accepted this cycle
comb_ch  in  NUM_BANKS*CH_W  channel per lane, lane 0 in LSBs
comb_data  in  NUM_BANKS*DATA_W  raw MUA data per lane
comb_hash  in  NUM_BANKS*DATA_W  channel hash per lane
comb_thr  in  NUM_BANKS*DATA_W  threshold per lane
comb_offset  in  NUM_BANKS*DATA_W  offset per lane, sampled with beat
out_valid  out  1  serial lane valid
out_ready  in  1  downstream ready (= !fifo_mua_full)
out_ch  out  CH_W  lane channel
out_data  out  DATA_W  offset-corrected data
out_thr  out  DATA_W  lane threshold
out_hash  out  DATA_W  lane hash
out_last  out  1  last lane of the current beat
out_frame_no  out  32  frame number of the current lane
drop_cnt  out  16  beats lost to overflow, saturating

Behaviour:
- Reset (xike_reset_n=0 at a bus_clk edge): FIFO empty, state IDLE, lane index 0, out_valid=0, out_last=0, out_ch/out_data/out_thr/out_hash=0, out_frame_no=0, drop_cnt=0. comb_ready=0 during reset. Reset mid-beat discards partial beats. Nothing is flushed.
- Input stage: comb_ready = !fifo_full. A beat is accepted when comb_valid && comb_ready.
- Offset correction: per lane, data - offset, DATA_W bits, modulo 2^DATA_W. If CLR_LSB=1, bit 0 is forced to 0.
- The corrected beat, with its ch, hash and thr, is registered one cycle and then written to the FIFO.
- A beat arriving while the FIFO is full is not written. drop_cnt increments by 1 and saturates at 0xFFFF.
- The pipeline register slot counts toward fullness, so no accepted beat is ever lost.
- FSM IDLE:
  - FIFO non-empty -> pop the head into the shift register, lane=0, go to SHIFT.
  - out_valid=0 in IDLE.
- FSM SHIFT:
  - out_valid=1. Outputs present lane `lane`.
  - out_last = (lane==NUM_BANKS-1).
  - On out_valid&&out_ready: lane++.
  - At the last lane: if the FIFO is non-empty, pop and reload in the same cycle with no bubble, lane=0. Otherwise go to IDLE.
  - out_ready=0 holds all outputs stable.
- Latency: a beat accepted at cycle t with the FIFO empty and the FSM idle produces lane 0 on out_valid at t+3. Steady throughput is one lane per cycle.
- Simultaneous FIFO push and pop in the same cycle are both honoured. Occupancy is unchanged.
- Frame counter:
  - 32-bit. out_frame_no is the count before the current lane.
  - Increments on an out handshake where out_ch==NUM_CH-1. Wraps 0xFFFFFFFF -> 0.
  - frame_count_rst=1 clears it to 0 and wins over a simultaneous increment.
  - frame_count_rst does not affect the data path.

Optional Feature:
MUA_SAT_SUB_EN:
- Defined: offset subtraction is signed saturating. Inputs are treated as two's complement. Results clamp to the min/max signed DATA_W values. CLR_LSB is applied after clamping.
- Undefined: modulo subtraction as described in Behaviour.

Test Plan:
1. Single beat, defaults; data lanes {100,200,300,400,501}, offsets {1,1,1,1,1}, ch {0..4}, out_ready=1 -> out_data 98,198,298,398,500; out_last only on ch4; lane 0 appears 3 cycles after acceptance.
2. Backpressure: out_ready toggles 1/0 each cycle during 2 back-to-back beats -> 10 lanes in order; outputs stable while stalled; no bubble between beats when ready is held high.
3. Overflow: out_ready=0, 8 consecutive comb_valid beats, FIFO_DEPTH=4 -> comb_ready falls after the FIFO fills; drop_cnt equals cycles with valid&&!ready; the 4 buffered beats drain intact after out_ready=1.
4. Frame count: 64 beats covering ch 0..159 twice -> out_frame_no is 0 for the first 160 lanes and 1 for the next 160; frame_count_rst pulsed on the ch159 handshake -> next lane shows 0.
5. Reset mid-SHIFT at lane 2 -> next cycle out_valid=0, drop_cnt=0, out_frame_no=0; a fresh beat afterwards serialises from lane 0.
6. MUA_SAT_SUB_EN: data 0x80000000, offset 1 -> 0x80000000, not 0x7FFFFFFE; without the macro -> 0x7FFFFFFE.
